// File: rtl/banzai_pkg.sv
// Shared types and widths for the Bayesian_stoch_log inference sequencer.
package banzai_pkg;

  localparam int unsigned N_CLASS = 4;
  localparam int unsigned OBS_W   = 6;
  localparam int unsigned ITER_W  = 16;
  localparam int unsigned PLEN_W  = 8;
  localparam int unsigned SEED_W  = 8;
  localparam int unsigned ADR_W   = 8;
  localparam int unsigned FIDX_W  = 2;
  localparam int unsigned OCNT_W  = 8;

  typedef enum logic [3:0] {
    IDLE, SEED, CLEAR, SETUP, PRE, PULSE, OFF, OUT, DONE
  } infer_state_t;

  // Registered chip-control bundle driven by the sequencer.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              csl;
    logic              cwl;
    logic              inference;
    logic              load_seed;
    logic              read_1;
    logic              load_mem;
    logic              read_out;
    logic              stoch_log;
    logic [ADR_W-1:0]  adr_col;
    logic [ADR_W-1:0]  adr_row;
    logic [SEED_W-1:0] seeds;
  } ctl_t;

endpackage

// File: rtl/banzai_class_cnt.sv
// Per-class saturating hit counters, cleared at the start of each run.
module banzai_class_cnt
  import banzai_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [N_CLASS-1:0]       inc,
  output logic [N_CLASS*CNT_W-1:0] counts
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      counts <= '0;
    end else begin
      for (int c = 0; c < N_CLASS; c++) begin
        if (inc[c] && (counts[c*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          counts[c*CNT_W +: CNT_W] <= counts[c*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/banzai_infer_seq.sv
// Inference sequencer: seeds the array, walks features per iteration,
// samples the per-class output bits and accumulates hit counts.
module banzai_infer_seq
  import banzai_pkg::*;
#(
  parameter int unsigned NFEAT   = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned OUT_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ITER_W-1:0]        n_iter,
  input  logic [PLEN_W-1:0]        pulse_len,
  input  logic [SEED_W-1:0]        seed,
  input  logic [NFEAT*OBS_W-1:0]   obs,
  output logic                     busy,
  output logic                     done,
  output logic [N_CLASS*CNT_W-1:0] counts,
  output logic                     CBL,
  output logic                     CBLEN,
  output logic                     CSL,
  output logic                     CWL,
  output logic                     inference,
  output logic                     load_seed,
  output logic                     read_1,
  output logic                     read_8,
  output logic                     load_mem,
  output logic                     read_out,
  output logic                     stoch_log,
  output logic [ADR_W-1:0]         adr_full_col,
  output logic [ADR_W-1:0]         adr_full_row,
  output logic [SEED_W-1:0]        seeds,
  input  logic [N_CLASS-1:0]       bit_out
);

  localparam logic [FIDX_W-1:0] F_LAST   = FIDX_W'(NFEAT - 1);
  localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_LAT);

  infer_state_t       state, nxt;
  logic [FIDX_W-1:0]  f_q, f_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ITER_W:0]    iter_nx;
  logic [PLEN_W-1:0]  pcnt_q, pcnt_d, plen_last;
  logic [OCNT_W-1:0]  ocnt_q, ocnt_d;
  logic [ITER_W-1:0]  n_iter_q;
  logic [PLEN_W-1:0]  pulse_len_q;
  logic [NFEAT*OBS_W-1:0] obs_q;
  logic [OBS_W-1:0]   obs_f;
  logic               go;
  logic [N_CLASS-1:0] inc;
  ctl_t               ctl_d, ctl_q;

  assign go        = (state == IDLE) && start && !abort;
  assign plen_last = (pulse_len_q == '0) ? '0 : pulse_len_q - PLEN_W'(1);
  assign iter_nx   = {1'b0, iter_q} + (ITER_W+1)'(1);
  assign inc       = ((state == OUT) && (ocnt_q == OUT_LAST) && !abort) ? bit_out : '0;

  // Next state and loop counters; abort overrides every transition.
  always_comb begin
    nxt    = state;
    f_d    = f_q;
    iter_d = iter_q;
    pcnt_d = pcnt_q;
    ocnt_d = ocnt_q;
    case (state)
      IDLE:  if (start) nxt = SEED;
      SEED:  begin
        iter_d = '0;
        nxt    = (n_iter_q == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        f_d = '0;
        nxt = SETUP;
      end
      SETUP: nxt = PRE;
      PRE:   begin
        pcnt_d = '0;
        nxt    = PULSE;
      end
      PULSE: begin
        if (pcnt_q == plen_last) nxt = OFF;
        else pcnt_d = pcnt_q + PLEN_W'(1);
      end
      OFF:   begin
        if (f_q != F_LAST) begin
          f_d = f_q + FIDX_W'(1);
          nxt = SETUP;
        end else begin
          ocnt_d = '0;
          nxt    = OUT;
        end
      end
      OUT:   begin
        if (ocnt_q == OUT_LAST) begin
          if (iter_nx < {1'b0, n_iter_q}) begin
            iter_d = iter_nx[ITER_W-1:0];
            nxt    = CLEAR;
          end else begin
            nxt = DONE;
          end
        end else begin
          ocnt_d = ocnt_q + OCNT_W'(1);
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    ctl_d      = '0;
    obs_f      = OBS_W'(obs_q >> (OBS_W * 32'(f_d)));
    ctl_d.busy = (nxt != IDLE) && (nxt != DONE);
    case (nxt)
      SEED: begin
        // SEED is only entered on the start edge, before seed could be latched.
        ctl_d.load_seed = 1'b1;
        ctl_d.seeds     = seed;
      end
      CLEAR: ctl_d.load_mem = 1'b1;
      SETUP, PRE, PULSE, OFF: begin
        ctl_d.stoch_log = 1'b1;
        ctl_d.read_1    = 1'b1;
        ctl_d.adr_row   = {f_d, obs_f};
        ctl_d.adr_col   = {f_d, OBS_W'(0)};
        ctl_d.csl       = (nxt == PRE);
        ctl_d.cwl       = (nxt == PRE) || (nxt == PULSE);
        ctl_d.inference = (nxt == OFF);
      end
      OUT: begin
        ctl_d.stoch_log = 1'b1;
        ctl_d.read_out  = 1'b1;
      end
      DONE:    ctl_d.done = 1'b1;
      default: ctl_d = ctl_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      f_q         <= '0;
      iter_q      <= '0;
      pcnt_q      <= '0;
      ocnt_q      <= '0;
      n_iter_q    <= '0;
      pulse_len_q <= '0;
      obs_q       <= '0;
      ctl_q       <= '0;
    end else begin
      state  <= nxt;
      f_q    <= f_d;
      iter_q <= iter_d;
      pcnt_q <= pcnt_d;
      ocnt_q <= ocnt_d;
      ctl_q  <= ctl_d;
      if (go) begin
        n_iter_q    <= n_iter;
        pulse_len_q <= pulse_len;
        obs_q       <= obs;
      end
    end
  end

  banzai_class_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (go),
    .inc    (inc),
    .counts (counts)
  );

  assign busy         = ctl_q.busy;
  assign done         = ctl_q.done;
  assign CSL          = ctl_q.csl;
  assign CWL          = ctl_q.cwl;
  assign inference    = ctl_q.inference;
  assign load_seed    = ctl_q.load_seed;
  assign read_1       = ctl_q.read_1;
  assign load_mem     = ctl_q.load_mem;
  assign read_out     = ctl_q.read_out;
  assign stoch_log    = ctl_q.stoch_log;
  assign adr_full_col = ctl_q.adr_col;
  assign adr_full_row = ctl_q.adr_row;
  assign seeds        = ctl_q.seeds;
  assign CBL          = 1'b0;
  assign CBLEN        = 1'b0;
  assign read_8       = 1'b0;

endmodule

// File: tb/tb_banzai_infer_seq.sv
// Directed self-checking bench for banzai_infer_seq (main instance plus a 4-bit-counter instance).
module tb_banzai_infer_seq;

  localparam int unsigned NFEAT = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, start_sat;
  logic [15:0] n_iter;
  logic [7:0]  pulse_len, seed;
  logic [23:0] obs;
  logic [3:0]  bit_out;

  logic        busy, done, CBL, CBLEN, CSL, CWL, inference, load_seed;
  logic        read_1, read_8, load_mem, read_out, stoch_log;
  logic [63:0] counts;
  logic [7:0]  adr_full_col, adr_full_row, seeds;

  logic        s_busy, s_done, s_CBL, s_CBLEN, s_CSL, s_CWL, s_inference, s_load_seed;
  logic        s_read_1, s_read_8, s_load_mem, s_read_out, s_stoch_log;
  logic [15:0] s_counts;
  logic [7:0]  s_adr_full_col, s_adr_full_row, s_seeds;

  logic [11:0] strb, s_strb;
  assign strb   = {CBL, CBLEN, CSL, CWL, inference, load_seed, read_1, read_8,
                   load_mem, read_out, stoch_log, done};
  assign s_strb = {s_CBL, s_CBLEN, s_CSL, s_CWL, s_inference, s_load_seed, s_read_1,
                   s_read_8, s_load_mem, s_read_out, s_stoch_log, s_done};

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  banzai_infer_seq #(.NFEAT(NFEAT), .CNT_W(CNT_W), .OUT_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .n_iter(n_iter),
    .pulse_len(pulse_len), .seed(seed), .obs(obs), .busy(busy), .done(done),
    .counts(counts), .CBL(CBL), .CBLEN(CBLEN), .CSL(CSL), .CWL(CWL),
    .inference(inference), .load_seed(load_seed), .read_1(read_1), .read_8(read_8),
    .load_mem(load_mem), .read_out(read_out), .stoch_log(stoch_log),
    .adr_full_col(adr_full_col), .adr_full_row(adr_full_row), .seeds(seeds),
    .bit_out(bit_out)
  );

  banzai_infer_seq #(.NFEAT(NFEAT), .CNT_W(SAT_W), .OUT_LAT(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .abort(abort), .n_iter(n_iter),
    .pulse_len(pulse_len), .seed(seed), .obs(obs), .busy(s_busy), .done(s_done),
    .counts(s_counts), .CBL(s_CBL), .CBLEN(s_CBLEN), .CSL(s_CSL), .CWL(s_CWL),
    .inference(s_inference), .load_seed(s_load_seed), .read_1(s_read_1),
    .read_8(s_read_8), .load_mem(s_load_mem), .read_out(s_read_out),
    .stoch_log(s_stoch_log), .adr_full_col(s_adr_full_col),
    .adr_full_row(s_adr_full_row), .seeds(s_seeds), .bit_out(bit_out)
  );

  typedef struct {
    logic [15:0] n_iter;
    logic [7:0]  pulse_len;
    logic [3:0]  bits;
    int          p;
    int          restart;
    int          lat;
    logic [63:0] counts;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full run: latency, counts, pulse widths, feature-2 addressing, seeding.
  task automatic run(input vec_t v, input string tag);
    int cyc, lm, run_len, pmin, pmax, win, row_bad, idle_cnt, seed_ok;
    n_iter    = v.n_iter;
    pulse_len = v.pulse_len;
    bit_out   = v.bits;
    start     = 1'b1;
    step();
    start    = 1'b0;
    cyc      = 1;
    lm       = 0;
    run_len  = 0;
    pmin     = 999;
    pmax     = 0;
    win      = 0;
    row_bad  = 0;
    idle_cnt = 0;
    seed_ok  = 0;
    forever begin
      if (load_mem) lm++;
      if (load_seed && seeds == seed) seed_ok++;
      if (CWL && !CSL) run_len++;
      else if (run_len != 0) begin
        if (run_len < pmin) pmin = run_len;
        if (run_len > pmax) pmax = run_len;
        run_len = 0;
      end
      if (lm == 1 && stoch_log && read_1 && adr_full_row[7:6] == 2'd2) begin
        win++;
        if (adr_full_row != 8'h95 || adr_full_col != 8'h80) row_bad++;
      end
      if (!busy && !done) idle_cnt++;
      if (done || cyc >= v.lat + 20) break;
      start = (cyc == v.restart);
      if (cyc == v.restart) begin
        n_iter    = 16'd9;
        pulse_len = 8'd5;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, " counts"}, counts, v.counts);
    chk({tag, " load_mem pulses"}, 64'(lm), 64'(v.n_iter));
    chk({tag, " busy gaps"}, 64'(idle_cnt), 64'd0);
    chk({tag, " seed load"}, 64'(seed_ok), 64'd1);
    if (v.n_iter != 16'd0) begin
      chk({tag, " min pulse"}, 64'(pmin), 64'(v.p));
      chk({tag, " max pulse"}, 64'(pmax), 64'(v.p));
      chk({tag, " feat2 window"}, 64'(win), 64'(3 + v.p));
      chk({tag, " feat2 address"}, 64'(row_bad), 64'd0);
    end
    step();
    chk({tag, " after done"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int cyc, dcnt;
    logic found;

    rst = 1'b1; start = 1'b0; abort = 1'b0; start_sat = 1'b0;
    n_iter = '0; pulse_len = '0; seed = 8'hA5; bit_out = '0;
    obs = {6'h2A, 6'h15, 6'h07, 6'h33};
    vecs[0] = '{16'd3, 8'd2, 4'b0101, 2, 0, 74,  64'h0000_0003_0000_0003};
    vecs[1] = '{16'd0, 8'd2, 4'b1111, 2, 0, 2,   64'h0};
    vecs[2] = '{16'd2, 8'd0, 4'b1010, 1, 10, 42, 64'h0002_0000_0002_0000};
    vecs[3] = '{16'd1, 8'd3, 4'b1000, 3, 0, 30,  64'h0001_0000_0000_0000};
    vecs[4] = '{16'd5, 8'd1, 4'b0110, 1, 0, 102, 64'h0000_0005_0005_0000};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset outputs", {28'd0, strb, busy, adr_full_row, adr_full_col, seeds}, 64'd0);
    chk("reset counts", counts, 64'd0);

    for (int i = 0; i < 5; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Saturation on the 4-bit-counter instance.
    n_iter = 16'd20; pulse_len = 8'd1; bit_out = 4'hF;
    start_sat = 1'b1;
    step();
    start_sat = 1'b0;
    cyc = 1;
    dcnt = 0;
    while (!s_done && cyc < 430) begin
      step();
      cyc++;
    end
    chk("sat latency", 64'(cyc), 64'd402);
    chk("sat counts", {48'd0, s_counts}, 64'h0000_0000_0000_FFFF);
    for (int i = 0; i < 6; i++) begin
      if (s_done) dcnt++;
      step();
    end
    chk("sat done pulses", 64'(dcnt), 64'd1);
    chk("sat idle outputs", {43'd0, s_strb, s_busy, s_adr_full_row[0], s_adr_full_col[0],
        s_seeds[7:0] != 8'd0, s_read_8}, 64'd0);

    // Abort during a PULSE of the second iteration.
    n_iter = 16'd3; pulse_len = 8'd2; bit_out = 4'h1;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    dcnt  = 0;
    for (int i = 0; i < 200; i++) begin
      if (load_mem) dcnt++;
      if (dcnt == 2 && CWL && !CSL) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("abort reached pulse", {63'd0, found}, 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort strobes", {51'd0, strb, busy}, 64'd0);
    chk("abort counts", counts, 64'h0000_0000_0000_0001);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dcnt++;
      step();
    end
    chk("abort stays idle", 64'(dcnt), 64'd0);

    v = '{16'd1, 8'd1, 4'b0001, 1, 0, 22, 64'h0000_0000_0000_0001};
    run(v, "post-abort");

    // Abort and start together in IDLE: abort wins, counts untouched.
    n_iter = 16'd4;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start+abort idle", {62'd0, busy, load_seed}, 64'd0);
    chk("start+abort counts", counts, 64'h0000_0000_0000_0001);

    // Reset in the middle of a run.
    n_iter = 16'd3; pulse_len = 8'd2; bit_out = 4'hF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    chk("pre-reset counts", counts, 64'h0001_0001_0001_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-run reset outputs", {51'd0, strb, busy}, 64'd0);
    chk("mid-run reset counts", counts, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
